// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin between the CPU (A) and the debug/loader port (B),
// with a starvation limit for B, a single-cycle read return path, and a guard on B writes to IO.
module dmem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int B_MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_wren,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [3:0]        a_byteena,
    input  logic [31:0]       a_data,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [31:0]       a_q,

    input  logic              b_req,
    input  logic              b_wren,
    input  logic [ADDR_W-1:0] b_address,
    input  logic [3:0]        b_byteena,
    input  logic [31:0]       b_data,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [31:0]       b_q,

    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteena,
    output logic [31:0]       mem_data,
    output logic              mem_wren,
    input  logic [31:0]       mem_q,

    output logic              b_err
);

    localparam int WAIT_W = (B_MAX_WAIT < 1) ? 1 : $clog2(B_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(B_MAX_WAIT);

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

    owner_t             last_q;
    owner_t             last_d;
    logic [WAIT_W-1:0]  b_wait_q;
    logic [WAIT_W-1:0]  b_wait_d;
    logic [ADDR_W-1:0]  mem_address_q;
    logic [ADDR_W-1:0]  mem_address_d;
    logic               b_err_q;
    logic               b_err_d;
    logic               grant_a;
    logic               grant_b;
    logic               b_reject;

    // Per-requester vectors so the return path can be built once for both ports.
    logic [1:0]         gnt_vec;
    logic [1:0]         wren_vec;
    logic [1:0]         rvalid_vec;
    logic [31:0]        q_vec [2];

    // ------------------------------------------------------------------
    // Arbitration: round-robin on ties, B forced ahead once it has waited
    // B_MAX_WAIT cycles; nothing is granted while reset is held.
    // ------------------------------------------------------------------
    always_comb begin
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        last_d   = last_q;
        b_wait_d = '0;

        if (!reset) begin
            if (a_req && b_req) begin
                if ((b_wait_q == WAIT_MAX) || (last_q == OWNER_A)) begin
                    grant_b = 1'b1;
                end else begin
                    grant_a = 1'b1;
                end
            end else if (a_req) begin
                grant_a = 1'b1;
            end else if (b_req) begin
                grant_b = 1'b1;
            end

            if (grant_a) begin
                last_d = OWNER_A;
            end else if (grant_b) begin
                last_d = OWNER_B;
            end

            if (b_req && !grant_b) begin
                b_wait_d = (b_wait_q == WAIT_MAX) ? b_wait_q : b_wait_q + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q   <= OWNER_B;
            b_wait_q <= '0;
        end else begin
            last_q   <= last_d;
            b_wait_q <= b_wait_d;
        end
    end

    assign a_gnt = grant_a;
    assign b_gnt = grant_b;

    // ------------------------------------------------------------------
    // Memory-side mux. A B write into the IO region is still granted so
    // that B is released, but its write strobes are suppressed.
    // ------------------------------------------------------------------
    always_comb begin
        mem_address_d = mem_address_q;
        mem_byteena   = 4'b0000;
        mem_data      = '0;
        mem_wren      = 1'b0;
        b_reject      = 1'b0;

        if (grant_a) begin
            mem_address_d = a_address;
            mem_data      = a_data;
            mem_wren      = a_wren;
            mem_byteena   = a_byteena;
        end else if (grant_b) begin
            mem_address_d = b_address;
            mem_data      = b_data;
            if (b_wren && b_address[ADDR_W-1]) begin
                b_reject = 1'b1;
            end else begin
                mem_wren    = b_wren;
                mem_byteena = b_byteena;
            end
        end
    end

    assign mem_address = mem_address_d;
    assign b_err_d     = b_err_q | b_reject;

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_address_q <= '0;
            b_err_q       <= 1'b0;
        end else begin
            mem_address_q <= mem_address_d;
            b_err_q       <= b_err_d;
        end
    end

    assign b_err = b_err_q;

    // ------------------------------------------------------------------
    // Read return path: one identical slice per requester.
    // ------------------------------------------------------------------
    assign gnt_vec  = {grant_b, grant_a};
    assign wren_vec = {b_wren, a_wren};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ret
            logic        rvalid_q;
            logic        rvalid_d;
            logic [31:0] hold_q;
            logic [31:0] hold_d;

            assign rvalid_d = gnt_vec[gi] & ~wren_vec[gi];
            assign hold_d   = rvalid_q ? mem_q : hold_q;

            always_ff @(posedge clock) begin
                if (reset) begin
                    rvalid_q <= 1'b0;
                    hold_q   <= '0;
                end else begin
                    rvalid_q <= rvalid_d;
                    hold_q   <= hold_d;
                end
            end

            // mem_q is only valid during the rvalid cycle, so it is shown live
            // there and the captured copy is shown afterwards.
            assign rvalid_vec[gi] = rvalid_q;
            assign q_vec[gi]      = hold_d;
        end
    endgenerate

    assign a_rvalid = rvalid_vec[0];
    assign b_rvalid = rvalid_vec[1];
    assign a_q      = q_vec[0];
    assign b_q      = q_vec[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: ties after reset, streaming reads, round-robin fairness,
// IO write rejection for B and reset during an in-flight read.
module tb_dmem_arbiter;

    localparam int ADDR_W = 12;

    logic              clock = 1'b0;
    logic              reset;
    logic              a_req, a_wren, b_req, b_wren;
    logic [ADDR_W-1:0] a_address, b_address;
    logic [3:0]        a_byteena, b_byteena;
    logic [31:0]       a_data, b_data;
    logic              a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [31:0]       a_q, b_q;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteena;
    logic [31:0]       mem_data;
    logic              mem_wren;
    logic [31:0]       mem_q;
    logic              b_err;

    int n_checks = 0;
    int n_errors = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .B_MAX_WAIT(4)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_wren(a_wren), .a_address(a_address), .a_byteena(a_byteena),
        .a_data(a_data), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_q(a_q),
        .b_req(b_req), .b_wren(b_wren), .b_address(b_address), .b_byteena(b_byteena),
        .b_data(b_data), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_q(b_q),
        .mem_address(mem_address), .mem_byteena(mem_byteena), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_q(mem_q), .b_err(b_err)
    );

    always #5 clock = ~clock;

    // Memory model: read data is a fixed pattern of the address, one cycle later.
    always @(posedge clock) begin
        mem_q <= 32'hCAFE_0000 | {20'h0, mem_address};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int refused;
        int max_refused;

        reset     = 1'b1;
        a_req     = 1'b1;  a_wren = 1'b0; a_address = 12'h004; a_byteena = 4'hF; a_data = '0;
        b_req     = 1'b1;  b_wren = 1'b0; b_address = 12'h008; b_byteena = 4'hF; b_data = '0;

        // Reset behaviour with both requesters already asking.
        tick();
        tick();
        mid();
        check("rst_a_gnt",   a_gnt, 0);
        check("rst_b_gnt",   b_gnt, 0);
        check("rst_wren",    mem_wren, 0);
        check("rst_byteena", mem_byteena, 0);
        tick();
        check("rst_a_rvalid", a_rvalid, 0);
        check("rst_b_rvalid", b_rvalid, 0);
        check("rst_a_q",      a_q, 0);
        check("rst_b_q",      b_q, 0);
        check("rst_b_err",    b_err, 0);
        check("rst_mem_addr", mem_address, 0);

        // First tie after reset: A then B, reads returned one cycle later.
        reset = 1'b0;
        mid();
        check("tie0_a_gnt", a_gnt, 1);
        check("tie0_b_gnt", b_gnt, 0);
        check("tie0_addr",  mem_address, 12'h004);
        tick();
        check("tie1_a_rvalid", a_rvalid, 1);
        check("tie1_a_q",      a_q, 32'hCAFE_0004);
        check("tie1_b_rvalid", b_rvalid, 0);
        mid();
        check("tie1_a_gnt", a_gnt, 0);
        check("tie1_b_gnt", b_gnt, 1);
        check("tie1_addr",  mem_address, 12'h008);
        tick();
        a_req = 1'b0;
        b_req = 1'b0;
        check("tie2_b_rvalid", b_rvalid, 1);
        check("tie2_b_q",      b_q, 32'hCAFE_0008);
        check("tie2_a_rvalid", a_rvalid, 0);
        check("tie2_a_q_hold", a_q, 32'hCAFE_0004);

        // Streaming A reads 0x010..0x013 with no bubbles.
        a_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_address = 12'h010 + 12'(i);
            mid();
            check("strm_a_gnt", a_gnt, 1);
            tick();
            check("strm_a_rvalid", a_rvalid, 1);
            check("strm_a_q", a_q, 32'hCAFE_0010 + 32'(i));
        end
        a_req = 1'b0;
        mid();
        check("strm_addr_hold", mem_address, 12'h013);
        check("strm_idle_be",   mem_byteena, 0);
        tick();
        check("strm_end_rvalid", a_rvalid, 0);
        check("strm_end_a_q",    a_q, 32'hCAFE_0013);

        // Both requesting continuously; last grant was A so B leads, then alternate.
        a_req = 1'b1; a_address = 12'h050;
        b_req = 1'b1; b_address = 12'h060;
        refused = 0;
        max_refused = 0;
        for (int k = 0; k < 8; k++) begin
            mid();
            check("rr_b_gnt", b_gnt, (k % 2 == 0) ? 1 : 0);
            check("rr_a_gnt", a_gnt, (k % 2 == 1) ? 1 : 0);
            if (b_gnt) refused = 0;
            else       refused++;
            if (refused > max_refused) max_refused = refused;
            tick();
            if (k == 0) check("rr_b_q", b_q, 32'hCAFE_0060);
        end
        check("rr_b_refused_max_le4", (max_refused <= 4) ? 1 : 0, 1);
        a_req = 1'b0;
        b_req = 1'b0;

        // Ordinary B write is passed through and does not flag an error.
        b_req = 1'b1; b_wren = 1'b1; b_address = 12'h020; b_data = 32'h0000_007F;
        mid();
        check("bwr_b_gnt",   b_gnt, 1);
        check("bwr_wren",    mem_wren, 1);
        check("bwr_data",    mem_data, 32'h0000_007F);
        tick();
        check("bwr_b_rvalid", b_rvalid, 0);
        check("bwr_b_err",    b_err, 0);

        // Tie with B asking for an IO write: A wins (last=B), B not yet rejected.
        a_req = 1'b1; a_wren = 1'b1; a_address = 12'h030; a_data = 32'h0000_0055;
        b_address = 12'h800;
        mid();
        check("io_tie_a_gnt", a_gnt, 1);
        check("io_tie_b_gnt", b_gnt, 0);
        check("io_tie_wren",  mem_wren, 1);
        check("io_tie_addr",  mem_address, 12'h030);
        tick();
        check("io_tie_b_err", b_err, 0);
        a_req = 1'b0; a_wren = 1'b0;
        mid();
        check("io_b_gnt",     b_gnt, 1);
        check("io_wren",      mem_wren, 0);
        check("io_byteena",   mem_byteena, 0);
        tick();
        b_req = 1'b0; b_wren = 1'b0;
        check("io_b_err",     b_err, 1);
        check("io_b_rvalid",  b_rvalid, 0);
        for (int i = 0; i < 10; i++) tick();
        check("io_b_err_sticky", b_err, 1);

        // A write into the IO region is passed through.
        a_req = 1'b1; a_wren = 1'b1; a_address = 12'h800; a_data = 32'h0000_00A5;
        mid();
        check("io_a_gnt",     a_gnt, 1);
        check("io_a_wren",    mem_wren, 1);
        check("io_a_byteena", mem_byteena, 4'hF);
        check("io_a_data",    mem_data, 32'h0000_00A5);
        tick();
        check("io_a_rvalid",  a_rvalid, 0);
        a_req = 1'b0; a_wren = 1'b0;
        mid();
        check("idle_wren",    mem_wren, 0);
        check("idle_addr",    mem_address, 12'h800);

        // Reset while an accepted A read is returning.
        a_req = 1'b1; a_address = 12'h040;
        mid();
        check("mr_a_gnt", a_gnt, 1);
        tick();
        reset = 1'b1;
        check("mr_a_rvalid_pre", a_rvalid, 1);
        check("mr_a_q_pre",      a_q, 32'hCAFE_0040);
        mid();
        check("mr_rst_a_gnt", a_gnt, 0);
        check("mr_rst_wren",  mem_wren, 0);
        tick();
        check("mr_a_rvalid",  a_rvalid, 0);
        check("mr_a_q",       a_q, 0);
        check("mr_b_err",     b_err, 0);
        check("mr_mem_addr",  mem_address, 0);
        reset = 1'b0;
        a_req = 1'b0;
        tick();
        check("mr_post_rvalid", a_rvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning word-address width presented to data memory (bit 11 selects IO write, bit 10 IO read).
REQ-002 SHALL have parameter B_MAX_WAIT, default 4, meaning the most cycles requester B may be refused while requesting before it is forced ahead.
REQ-003 SHALL have ports `clock` (input, 1, sole clock, all state on rising edge) and `reset` (input, 1, synchronous, active-high).
REQ-004 SHALL have requester A (CPU load/store) ports:
- inputs: `a_req` 1, `a_wren` 1, `a_address` ADDR_W, `a_byteena` 4, `a_data` 32
- outputs: `a_gnt` 1, `a_rvalid` 1, `a_q` 32
REQ-005 SHALL have requester B (debug/loader) ports: `b_req`, `b_wren`, `b_address`, `b_byteena`, `b_data`, `b_gnt`, `b_rvalid`, `b_q`, with the same directions and widths as A.
REQ-006 SHALL have memory-side ports:
- outputs: `mem_address` ADDR_W, `mem_byteena` 4, `mem_data` 32, `mem_wren` 1
- input: `mem_q` 32, valid one cycle after the address is presented.
REQ-007 SHALL have output `b_err` 1, a sticky flag for a rejected B write into the IO region.

Function
REQ-008 SHALL grant at most one requester per cycle; `a_gnt` and `b_gnt` SHALL be combinational from the current requests and state, and are never both 1.
REQ-009 SHALL drive the `mem_*` outputs from the granted requester's `address`/`byteena`/`data`/`wren` in the grant cycle. With no grant, `mem_wren`=0, `mem_byteena`=0 and `mem_address` holds its last value.
REQ-010 SHALL treat a request as accepted in the cycle where req=1 and gnt=1; the requester holds all fields stable until accepted.
REQ-011 SHALL arbitrate round-robin via register `last` (A or B):
- if both request, grant the one that is not `last`;
- if one requests, grant it;
- `last` updates to the granted requester on every grant.
REQ-012 SHALL keep counter `b_wait` (saturating at B_MAX_WAIT):
- increments each cycle b_req=1 and b_gnt=0;
- clears on B grant or when b_req=0;
- when `b_wait`==B_MAX_WAIT, grant B regardless of `last`.
REQ-013 SHALL, for an accepted read (wren=0), assert that requester's rvalid for exactly the next cycle, with its q = `mem_q`; the other requester's rvalid stays 0.
REQ-014 SHALL allow back-to-back accepted reads every cycle from either or alternating requesters, each returning rvalid in order one cycle later (zero bubble).
REQ-015 SHALL return no rvalid for accepted writes.
REQ-016 SHALL hold a_q/b_q at their last returned value when rvalid=0.
REQ-017 SHALL reject a B write with `b_address`[ADDR_W-1]=1 (IO output region):
- still grant it (B is released);
- force `mem_wren`=0 and `mem_byteena`=0 that cycle;
- set `b_err`=1 from the next cycle until reset.
A writes to IO are passed through.
REQ-018 SHALL, on simultaneous A grant and B rejection-eligible request, apply REQ-017 only when B is actually granted.

Reset
REQ-019 SHALL, while `reset`=1 at a clock edge, clear on that edge:
- `last`=B, so A wins the first tie;
- `b_wait`=0, `a_rvalid`=0, `b_rvalid`=0, `a_q`=0, `b_q`=0, `b_err`=0, `mem_address`=0.
REQ-020 SHALL, while `reset` is high, force `a_gnt`=`b_gnt`=0, `mem_wren`=0 and `mem_byteena`=0.
REQ-021 SHALL drop any read in flight when reset is asserted; no rvalid appears after reset for that read.

Verification
REQ-022 SHALL cover the first tie after reset: a_req=b_req=1 reads at addresses 0x004/0x008, held two cycles → cycle0 a_gnt, cycle1 b_gnt; a_rvalid in cycle1 and b_rvalid in cycle2 with the respective mem_q values.
REQ-023 SHALL cover the B starvation limit: B requests continuously, and A requests continuously while `last`=A is forced by the test (e.g. A re-requests after a B grant) → B is never refused more than 4 consecutive cycles.
REQ-024 SHALL cover a B IO write:
- stimulus: b_wren=1, b_address=0x800, b_data=0x7F;
- required: b_gnt=1, mem_wren=0, b_err=1 next cycle and still 1 after ten idle cycles;
- a following A write to 0x800 gives mem_wren=1.
REQ-025 SHALL cover streaming reads: A reads 0x010..0x013 on four consecutive cycles → a_rvalid high four consecutive cycles, data in address order, no gaps.
REQ-026 SHALL cover reset mid-read: an A read is accepted, then reset is asserted the next cycle → a_rvalid=0 and a_q=0 after the edge, and a_gnt=0 during reset.
